// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the SRAM-like instruction memory (slave).
interface fetch_stage_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch front end: PC, request tracking, return FIFO to decode.
// Optional macro FETCH_PERF_CNT_EN adds bubble_cnt / redirect_cnt counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stallD,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master mem,
  output logic [31:0]   instrD,
  output logic [31:0]   pcD,
  output logic          validD,
  output logic          addrErrorD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   bubble_cnt,
  output logic [31:0]   redirect_cnt
`endif
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic             halted_q, halted_d;
  logic             hold_q, hold_d;
  logic             hold_stale_q, hold_stale_d;
  logic [31:0]      hold_addr_q, hold_addr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d;
  logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d;
  logic [PTR_W-1:0] fly_rd_q, fly_rd_d;
  logic [PTR_W-1:0] fly_wr_q, fly_wr_d;

  logic [31:0] fifo_pc_mem    [BUF_DEPTH];
  logic [31:0] fifo_instr_mem [BUF_DEPTH];
  logic        fifo_adel_mem  [BUF_DEPTH];
  logic [31:0] fly_pc_mem     [BUF_DEPTH];

  logic        req;
  logic        issue;
  logic        ack;
  logic        ack_stale;
  logic        data_ok;
  logic        drop;
  logic        push_data;
  logic        push_adel;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pc_aligned;
  logic [31:0] push_pc;
  logic [31:0] push_instr;

  assign mem.inst_req  = req;
  assign mem.inst_addr = hold_q ? hold_addr_q : pc_q;

  always_comb begin
    fifo_empty = (fifo_count_q == '0);
    fifo_full  = (fifo_count_q == CNT_W'(BUF_DEPTH));
    pc_aligned = (pc_q[1:0] == 2'b00);
    // Every issued request reserves a FIFO slot, so returns can never overflow it.
    issue      = !hold_q && !halted_q && pc_aligned &&
                 ((32'(fifo_count_q) + 32'(outstanding_q)) < 32'(BUF_DEPTH));
    req        = !rst && (hold_q || issue);
    ack        = req && mem.inst_addr_ok;
    ack_stale  = ack && hold_q && hold_stale_q;
    // A data_ok with nothing in flight (e.g. left over from before reset) is ignored.
    data_ok    = mem.inst_data_ok && (outstanding_q != '0);
    drop       = data_ok && (redirect || (discard_q != '0));
    push_data  = data_ok && !drop;
    push_adel  = !redirect && !halted_q && !pc_aligned && !hold_q &&
                 (outstanding_q == '0) && !fifo_full;
    fifo_push  = push_data || push_adel;
    validD     = !fifo_empty;
    fifo_pop   = validD && !stallD && !redirect;
    push_pc    = push_adel ? pc_q : fly_pc_mem[fly_rd_q];
    push_instr = push_adel ? 32'h0 : mem.inst_rdata;
    instrD     = validD ? fifo_instr_mem[fifo_rd_q] : 32'h0;
    pcD        = validD ? fifo_pc_mem[fifo_rd_q] : 32'h0;
    addrErrorD = validD && fifo_adel_mem[fifo_rd_q];
  end

  always_comb begin
    pc_d = pc_q;
    // A stale request was issued for the pre-redirect path; pc already points at the new path.
    if (ack && !ack_stale) begin
      pc_d = pc_q + 32'd4;
    end
    if (redirect) begin
      pc_d = redirect_pc;
    end

    halted_d = halted_q;
    if (push_adel) begin
      halted_d = 1'b1;
    end
    if (redirect) begin
      halted_d = 1'b0;
    end

    hold_d       = req && !ack;
    hold_addr_d  = mem.inst_addr;
    hold_stale_d = req && !ack && ((hold_q && hold_stale_q) || redirect);

    outstanding_d = outstanding_q + CNT_W'(ack) - CNT_W'(data_ok);
    if (redirect) begin
      discard_d = outstanding_d;
    end else begin
      discard_d = discard_q + CNT_W'(ack_stale) - CNT_W'(data_ok && (discard_q != '0));
    end

    if (redirect) begin
      fifo_count_d = '0;
      fifo_rd_d    = '0;
      fifo_wr_d    = '0;
    end else begin
      fifo_count_d = fifo_count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
      fifo_rd_d    = fifo_rd_q + PTR_W'(fifo_pop);
      fifo_wr_d    = fifo_wr_q + PTR_W'(fifo_push);
    end

    fly_wr_d = fly_wr_q + PTR_W'(ack);
    fly_rd_d = fly_rd_q + PTR_W'(data_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      halted_q      <= 1'b0;
      hold_q        <= 1'b0;
      hold_stale_q  <= 1'b0;
      hold_addr_q   <= 32'h0;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_count_q  <= '0;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      fly_rd_q      <= '0;
      fly_wr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      halted_q      <= halted_d;
      hold_q        <= hold_d;
      hold_stale_q  <= hold_stale_d;
      hold_addr_q   <= hold_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_count_q  <= fifo_count_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fly_rd_q      <= fly_rd_d;
      fly_wr_q      <= fly_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_pc_mem[fifo_wr_q]    <= push_pc;
      fifo_instr_mem[fifo_wr_q] <= push_instr;
      fifo_adel_mem[fifo_wr_q]  <= push_adel;
    end
    if (ack) begin
      fly_pc_mem[fly_wr_q] <= mem.inst_addr;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    bubble_cnt_d   = bubble_cnt_q + 32'(!validD);
    redirect_cnt_d = redirect_cnt_q + 32'(redirect);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q   <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      bubble_cnt_q   <= bubble_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign bubble_cnt   = bubble_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle-by-cycle bench for fetch_stage with hand-derived expectations.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stallD;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        addrErrorD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage_if mif();

  fetch_stage #(
    .RESET_PC  (32'hBFC0_0000),
    .BUF_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stallD      (stallD),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem         (mif),
    .instrD      (instrD),
    .pcD         (pcD),
    .validD      (validD),
    .addrErrorD  (addrErrorD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .bubble_cnt  (bubble_cnt),
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && validD && !stallD && !redirect)
      $display("decode accepts pc=%h instr=%h adel=%b", pcD, instrD, addrErrorD);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a_ok, input logic d_ok, input logic [31:0] rdata);
    mif.inst_addr_ok = a_ok;
    mif.inst_data_ok = d_ok;
    mif.inst_rdata   = rdata;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stallD = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    drive(1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_req",   32'(mif.inst_req), 32'd0);
    chk("rst_valid", 32'(validD),       32'd0);
    chk("rst_instr", instrD,            32'h0);
    chk("rst_pc",    pcD,               32'h0);
    chk("rst_adel",  32'(addrErrorD),   32'd0);

    // Zero-wait accept, 1-cycle data: validD from cycle 3, then one per cycle.
    rst = 1'b0; drive(1'b1, 1'b0, 32'h0); #1;
    chk("c1_req",  32'(mif.inst_req), 32'd1);
    chk("c1_addr", mif.inst_addr,     32'hBFC0_0000);
    tick();
    chk("c2_valid", 32'(validD),   32'd0);
    chk("c2_addr",  mif.inst_addr, 32'hBFC0_0004);
    drive(1'b1, 1'b1, 32'hA000_0000); tick();
    chk("c3_valid", 32'(validD),   32'd1);
    chk("c3_pc",    pcD,           32'hBFC0_0000);
    chk("c3_instr", instrD,        32'hA000_0000);
    chk("c3_addr",  mif.inst_addr, 32'hBFC0_0008);
    drive(1'b1, 1'b1, 32'hA000_0001); tick();
    chk("c4_valid", 32'(validD), 32'd1);
    chk("c4_pc",    pcD,         32'hBFC0_0004);
    chk("c4_instr", instrD,      32'hA000_0001);
    drive(1'b1, 1'b1, 32'hA000_0002); tick();
    chk("c5_pc", pcD, 32'hBFC0_0008);

    // Stall for 5 cycles: FIFO fills to 4 and requests stop.
    stallD = 1'b1; drive(1'b1, 1'b1, 32'hA000_0003); tick();
    chk("c6_req",  32'(mif.inst_req), 32'd1);
    chk("c6_addr", mif.inst_addr,     32'hBFC0_0014);
    chk("c6_pc",   pcD,               32'hBFC0_0008);
    drive(1'b1, 1'b1, 32'hA000_0004); tick();
    chk("c7_req", 32'(mif.inst_req), 32'd0);
    drive(1'b0, 1'b1, 32'hA000_0005); tick();
    chk("c8_req",   32'(mif.inst_req), 32'd0);
    chk("c8_pc",    pcD,               32'hBFC0_0008);
    chk("c8_instr", instrD,            32'hA000_0002);
    drive(1'b0, 1'b0, 32'h0); tick();
    chk("c9_req", 32'(mif.inst_req), 32'd0);
    chk("c9_pc",  pcD,               32'hBFC0_0008);
    stallD = 1'b0; tick();
    chk("c10_pc",    pcD,               32'hBFC0_000C);
    chk("c10_instr", instrD,            32'hA000_0003);
    chk("c10_req",   32'(mif.inst_req), 32'd1);
    chk("c10_addr",  mif.inst_addr,     32'hBFC0_0018);
    tick();
    chk("c11_pc",    pcD,    32'hBFC0_0010);
    chk("c11_instr", instrD, 32'hA000_0004);
    tick();
    chk("c12_pc",    pcD,    32'hBFC0_0014);
    chk("c12_instr", instrD, 32'hA000_0005);
    tick();
    chk("c13_valid", 32'(validD),   32'd0);
    chk("c13_instr", instrD,        32'h0);
    chk("c13_addr",  mif.inst_addr, 32'hBFC0_0018);

    // Held request across a redirect: address stays, its word is discarded.
    tick();
    chk("c14_addr", mif.inst_addr, 32'hBFC0_0018);
    redirect = 1'b1; redirect_pc = 32'h8000_0180; tick();
    redirect = 1'b0;
    chk("c15_req",  32'(mif.inst_req), 32'd1);
    chk("c15_addr", mif.inst_addr,     32'hBFC0_0018);
    tick();
    chk("c16_addr", mif.inst_addr, 32'hBFC0_0018);
    drive(1'b1, 1'b0, 32'h0); tick();
    chk("c17_addr",  mif.inst_addr, 32'h8000_0180);
    chk("c17_valid", 32'(validD),   32'd0);
    drive(1'b1, 1'b1, 32'hDEAD_BEEF); tick();
    chk("c18_valid", 32'(validD),   32'd0);
    chk("c18_addr",  mif.inst_addr, 32'h8000_0184);
    drive(1'b0, 1'b1, 32'hB000_0000); tick();
    chk("c19_valid", 32'(validD), 32'd1);
    chk("c19_pc",    pcD,         32'h8000_0180);
    chk("c19_instr", instrD,      32'hB000_0000);

    // Redirect with two requests outstanding plus one pending unacked.
    drive(1'b1, 1'b0, 32'h0); tick();
    chk("c20_addr",  mif.inst_addr, 32'h8000_0188);
    chk("c20_valid", 32'(validD),   32'd0);
    tick();
    chk("c21_addr", mif.inst_addr, 32'h8000_018C);
    redirect = 1'b1; redirect_pc = 32'h8000_0180; drive(1'b0, 1'b0, 32'h0); tick();
    redirect = 1'b0;
    chk("c22_addr",  mif.inst_addr, 32'h8000_018C);
    chk("c22_valid", 32'(validD),   32'd0);
    drive(1'b1, 1'b1, 32'hC000_0000); tick();
    chk("c23_addr",  mif.inst_addr, 32'h8000_0180);
    chk("c23_valid", 32'(validD),   32'd0);
    drive(1'b0, 1'b1, 32'hC000_0001); tick();
    chk("c24_valid", 32'(validD), 32'd0);
    drive(1'b0, 1'b1, 32'hC000_0002); tick();
    chk("c25_valid", 32'(validD),   32'd0);
    chk("c25_addr",  mif.inst_addr, 32'h8000_0180);
    drive(1'b1, 1'b0, 32'h0); tick();
    chk("c26_addr", mif.inst_addr, 32'h8000_0184);
    drive(1'b0, 1'b1, 32'hD000_0000); tick();
    chk("c27_valid", 32'(validD), 32'd1);
    chk("c27_pc",    pcD,         32'h8000_0180);
    chk("c27_instr", instrD,      32'hD000_0000);

    // Misaligned redirect: no request, one AdEL entry, then halted.
    redirect = 1'b1; redirect_pc = 32'h8000_0002; drive(1'b0, 1'b0, 32'h0); tick();
    redirect = 1'b0;
    chk("c28_valid", 32'(validD),       32'd0);
    chk("c28_req",   32'(mif.inst_req), 32'd1);
    chk("c28_addr",  mif.inst_addr,     32'h8000_0184);
    drive(1'b1, 1'b0, 32'h0); tick();
    chk("c29_req", 32'(mif.inst_req), 32'd0);
    drive(1'b0, 1'b1, 32'hBAD0_0001); tick();
    chk("c30_req",   32'(mif.inst_req), 32'd0);
    chk("c30_valid", 32'(validD),       32'd0);
    drive(1'b0, 1'b0, 32'h0); tick();
    chk("c31_valid", 32'(validD),       32'd1);
    chk("c31_adel",  32'(addrErrorD),   32'd1);
    chk("c31_instr", instrD,            32'h0);
    chk("c31_pc",    pcD,               32'h8000_0002);
    chk("c31_req",   32'(mif.inst_req), 32'd0);
    stallD = 1'b1; tick();
    chk("c32_valid", 32'(validD),     32'd1);
    chk("c32_adel",  32'(addrErrorD), 32'd1);
    stallD = 1'b0; tick();
    chk("c33_valid", 32'(validD),       32'd0);
    chk("c33_req",   32'(mif.inst_req), 32'd0);
    chk("c33_adel",  32'(addrErrorD),   32'd0);
    tick();
    chk("c34_valid", 32'(validD),       32'd0);
    chk("c34_req",   32'(mif.inst_req), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h8000_0000; tick();
    redirect = 1'b0;
    chk("c35_req",  32'(mif.inst_req), 32'd1);
    chk("c35_addr", mif.inst_addr,     32'h8000_0000);
    drive(1'b1, 1'b0, 32'h0); tick();
    chk("c36_addr", mif.inst_addr, 32'h8000_0004);

    // Reset mid-burst with data_ok pending; late data_ok must be ignored.
    rst = 1'b1; drive(1'b1, 1'b1, 32'hBAD0_0002); tick();
    chk("c37_req",   32'(mif.inst_req), 32'd0);
    chk("c37_valid", 32'(validD),       32'd0);
    chk("c37_pc",    pcD,               32'h0);
    rst = 1'b0; drive(1'b0, 1'b1, 32'hBAD0_0003); #1;
    chk("c37_req_after", 32'(mif.inst_req), 32'd1);
    chk("c37_addr",      mif.inst_addr,     32'hBFC0_0000);
    tick();
    chk("c38_valid", 32'(validD),   32'd0);
    chk("c38_addr",  mif.inst_addr, 32'hBFC0_0000);
    drive(1'b1, 1'b0, 32'h0); tick();
    chk("c39_valid", 32'(validD), 32'd0);
    drive(1'b0, 1'b1, 32'hF000_0000); tick();
    chk("c40_valid", 32'(validD), 32'd1);
    chk("c40_pc",    pcD,         32'hBFC0_0000);
    chk("c40_instr", instrD,      32'hF000_0000);
    drive(1'b0, 1'b0, 32'h0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
